// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: word width, DVI control tokens and the
// deserializer alignment FSM states.
package tmds_pkg;

    localparam int unsigned TMDS_WORD_W = 10;

    // Control tokens, bits 9..0, indexed by {C1,C0}
    localparam logic [TMDS_WORD_W-1:0] TMDS_TOKEN_00 = 10'b1101010100;
    localparam logic [TMDS_WORD_W-1:0] TMDS_TOKEN_01 = 10'b0010101011;
    localparam logic [TMDS_WORD_W-1:0] TMDS_TOKEN_10 = 10'b0101010100;
    localparam logic [TMDS_WORD_W-1:0] TMDS_TOKEN_11 = 10'b1010101011;

    typedef enum logic [1:0] {
        SEARCH,
        VERIFY,
        LOCKED
    } tmds_align_state_e;

endpackage

// File: rtl/tmds_token_detect.sv
// Combinational DVI control-token matcher: flags a token and returns its {C1,C0}.
module tmds_token_detect
    import tmds_pkg::*;
(
    input  logic [TMDS_WORD_W-1:0] word_i,
    output logic                   hit_o,
    output logic [1:0]             ctrl_o
);

    // Match the word against the four control tokens
    always_comb begin
        hit_o  = 1'b1;
        ctrl_o = 2'b00;
        case (word_i)
            TMDS_TOKEN_00: ctrl_o = 2'b00;
            TMDS_TOKEN_01: ctrl_o = 2'b01;
            TMDS_TOKEN_10: ctrl_o = 2'b10;
            TMDS_TOKEN_11: ctrl_o = 2'b11;
            default:       hit_o  = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_deserializer.sv
// TMDS receive deserializer: shifts three serial lanes, finds the 10-bit word
// boundary from blue-lane control tokens, and emits aligned words with a
// one-cycle valid strobe plus decoded de/hsync/vsync.
module tmds_deserializer
    import tmds_pkg::*;
#(
    parameter int unsigned TOKEN_RUN  = 8,
    parameter int unsigned LOSS_WORDS = 2048
) (
    input  logic       clk_fast,
    input  logic       rst_n,
    input  logic [2:0] TMDS_in,
    output logic [9:0] TMDS_red,
    output logic [9:0] TMDS_green,
    output logic [9:0] TMDS_blue,
    output logic       word_valid,
    output logic       locked,
    output logic       de,
    output logic       hsync,
    output logic       vsync
);

    localparam logic [3:0]  RUN_TGT  = 4'(TOKEN_RUN);
    localparam logic [11:0] LOSS_TGT = 12'(LOSS_WORDS);

    tmds_align_state_e state_q, state_d;

    logic [9:0]  sr_r_q, sr_r_d, sr_g_q, sr_g_d, sr_b_q, sr_b_d;
    logic [9:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [3:0]  phase_q, phase_d;
    logic [3:0]  run_q, run_d;
    logic [11:0] loss_q, loss_d;
    logic [11:0] loss_inc;
    logic        word_valid_q, word_valid_d;
    logic        locked_q, locked_d;
    logic        de_q, de_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        boundary;
    logic        tok_hit;
    logic [1:0]  tok_ctrl;

    tmds_token_detect u_blue_tok (
        .word_i (sr_b_q),
        .hit_o  (tok_hit),
        .ctrl_o (tok_ctrl)
    );

    // State and datapath registers
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= SEARCH;
            sr_r_q       <= '0;
            sr_g_q       <= '0;
            sr_b_q       <= '0;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
            phase_q      <= '0;
            run_q        <= '0;
            loss_q       <= '0;
            word_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            de_q         <= 1'b0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_r_q       <= sr_r_d;
            sr_g_q       <= sr_g_d;
            sr_b_q       <= sr_b_d;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
            phase_q      <= phase_d;
            run_q        <= run_d;
            loss_q       <= loss_d;
            word_valid_q <= word_valid_d;
            locked_q     <= locked_d;
            de_q         <= de_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
        end
    end

    // Alignment FSM next state, word capture and status outputs
    always_comb begin
        sr_r_d       = {TMDS_in[2], sr_r_q[9:1]};
        sr_g_d       = {TMDS_in[1], sr_g_q[9:1]};
        sr_b_d       = {TMDS_in[0], sr_b_q[9:1]};
        phase_d      = (phase_q == 4'd9) ? '0 : phase_q + 4'd1;
        state_d      = state_q;
        run_d        = run_q;
        loss_d       = loss_q;
        word_valid_d = 1'b0;
        locked_d     = locked_q;
        de_d         = de_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        boundary     = (phase_q == '0);
        loss_inc     = (loss_q == '1) ? loss_q : loss_q + 12'd1;

        case (state_q)
            SEARCH: begin
                // A token in the sliding window forces the word boundary here
                if (tok_hit) begin
                    boundary = 1'b1;
                    phase_d  = 4'd1;
                    run_d    = 4'd1;
                    state_d  = VERIFY;
                end
            end
            VERIFY: begin
                if (boundary) begin
                    if (tok_hit) begin
                        run_d = run_q + 4'd1;
                        if (run_q + 4'd1 == RUN_TGT) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                            loss_d   = '0;
                        end
                    end else begin
                        state_d = SEARCH;
                    end
                end
            end
            LOCKED: begin
                if (boundary) begin
                    if (tok_hit) begin
                        de_d         = 1'b0;
                        hsync_d      = tok_ctrl[0];
                        vsync_d      = tok_ctrl[1];
                        loss_d       = '0;
                        word_valid_d = 1'b1;
                    end else begin
                        loss_d = loss_inc;
                        if (loss_inc == LOSS_TGT) begin
                            state_d  = SEARCH;
                            locked_d = 1'b0;
                            de_d     = 1'b0;
                        end else begin
                            de_d         = 1'b1;
                            word_valid_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = SEARCH;
        endcase

        red_d   = boundary ? sr_r_q : red_q;
        green_d = boundary ? sr_g_q : green_q;
        blue_d  = boundary ? sr_b_q : blue_q;
    end

    assign TMDS_red   = red_q;
    assign TMDS_green = green_q;
    assign TMDS_blue  = blue_q;
    assign word_valid = word_valid_q;
    assign locked     = locked_q;
    assign de         = de_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;

endmodule

// File: tb/tb_tmds_deserializer.sv
// Self-checking bench for tmds_deserializer: word-level reference model of
// alignment, lock, loss-of-lock and sync decoding driven by serialized words.
module tb_tmds_deserializer;

    localparam int TR = 8;
    localparam int LW = 16;

    logic       clk_fast = 1'b0;
    logic       rst_n    = 1'b0;
    logic [2:0] TMDS_in  = '0;
    logic [9:0] TMDS_red, TMDS_green, TMDS_blue;
    logic       word_valid, locked, de, hsync, vsync;

    int total = 0;
    int bad   = 0;

    logic [9:0] qr[$];
    logic [9:0] qg[$];
    logic [9:0] qb[$];

    always #5 clk_fast = ~clk_fast;

    tmds_deserializer #(.TOKEN_RUN(TR), .LOSS_WORDS(LW)) dut (
        .clk_fast   (clk_fast),
        .rst_n      (rst_n),
        .TMDS_in    (TMDS_in),
        .TMDS_red   (TMDS_red),
        .TMDS_green (TMDS_green),
        .TMDS_blue  (TMDS_blue),
        .word_valid (word_valid),
        .locked     (locked),
        .de         (de),
        .hsync      (hsync),
        .vsync      (vsync)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk10(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // DVI control token table, {C1,C0} decode
    function automatic void tok_of(input logic [9:0] w, output bit hit, output bit c0, output bit c1);
        hit = 1'b1; c0 = 1'b0; c1 = 1'b0;
        case (w)
            10'h354: begin c1 = 1'b0; c0 = 1'b0; end
            10'h0AB: begin c1 = 1'b0; c0 = 1'b1; end
            10'h154: begin c1 = 1'b1; c0 = 1'b0; end
            10'h2AB: begin c1 = 1'b1; c0 = 1'b1; end
            default: hit = 1'b0;
        endcase
    endfunction

    function automatic logic [9:0] rand_data();
        logic [9:0] w;
        bit h, a, b;
        do begin
            w = 10'($urandom);
            tok_of(w, h, a, b);
        end while (h);
        return w;
    endfunction

    task automatic push(input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
        qr.push_back(r); qg.push_back(g); qb.push_back(b);
    endtask

    task automatic check_zero(input string tag);
        chk10({tag, "_red"}, TMDS_red, 10'h000);
        chk10({tag, "_green"}, TMDS_green, 10'h000);
        chk10({tag, "_blue"}, TMDS_blue, 10'h000);
        chk1({tag, "_wv"}, word_valid, 1'b0);
        chk1({tag, "_locked"}, locked, 1'b0);
        chk1({tag, "_de"}, de, 1'b0);
        chk1({tag, "_hsync"}, hsync, 1'b0);
        chk1({tag, "_vsync"}, vsync, 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            TMDS_in = 3'($urandom);
            @(posedge clk_fast); #1;
            check_zero(tag);
        end
        rst_n = 1'b1;
        qr.delete(); qg.delete(); qb.delete();
    endtask

    // Serialize queued words LSB first after a random 3-bit preamble and check
    // every cycle against a word-level model of the alignment rules.
    task automatic run_words(input string tag);
        int  n;
        int  st;     // 0 search, 1 verify, 2 locked, 3 search after failure
        int  run, loss, w;
        bit  lk, hs, vs, vexp, dexp, hit, c0, c1;
        logic [9:0] r, g, b;
        n = qb.size();
        st = 0; run = 0; loss = 0; lk = 0; hs = 0; vs = 0; dexp = 0;
        for (int i = 0; i < 3; i++) begin
            TMDS_in = 3'($urandom);
            @(posedge clk_fast); #1;
            chk1({tag, "_pre_wv"}, word_valid, 1'b0);
            chk1({tag, "_pre_locked"}, locked, 1'b0);
        end
        for (int k = 0; k <= n; k++) begin
            for (int bi = 0; bi < 10; bi++) begin
                if (k == n && bi > 0) break;
                if (k < n) begin
                    r = qr[k]; g = qg[k]; b = qb[k];
                    TMDS_in = {r[bi], g[bi], b[bi]};
                end else begin
                    TMDS_in = 3'($urandom);
                end
                @(posedge clk_fast); #1;
                if (bi == 0 && k > 0) begin
                    w = k - 1;
                    tok_of(qb[w], hit, c0, c1);
                    vexp = 1'b0;
                    case (st)
                        0: if (hit) begin st = 1; run = 1; end
                        1: if (hit) begin
                               run++;
                               if (run == TR) begin st = 2; lk = 1'b1; loss = 0; end
                           end else st = 3;
                        2: if (hit) begin
                               hs = c0; vs = c1; loss = 0; vexp = 1'b1; dexp = 1'b0;
                           end else begin
                               loss++;
                               if (loss == LW) begin st = 3; lk = 1'b0; dexp = 1'b0; end
                               else begin vexp = 1'b1; dexp = 1'b1; end
                           end
                        default: ;
                    endcase
                    chk1({tag, "_wv"}, word_valid, vexp);
                    chk1({tag, "_locked"}, locked, lk);
                    if (vexp) begin
                        chk10({tag, "_red"}, TMDS_red, qr[w]);
                        chk10({tag, "_green"}, TMDS_green, qg[w]);
                        chk10({tag, "_blue"}, TMDS_blue, qb[w]);
                        chk1({tag, "_de"}, de, dexp);
                        chk1({tag, "_hsync"}, hsync, hs);
                        chk1({tag, "_vsync"}, vsync, vs);
                    end
                end else begin
                    chk1({tag, "_wv_idle"}, word_valid, 1'b0);
                    chk1({tag, "_locked_hold"}, locked, lk);
                end
                if (!lk) chk1({tag, "_de_unlocked"}, de, 1'b0);
            end
        end
    endtask

    initial begin
        // Reset, then basic alignment on token 00
        do_reset("rst");
        for (int i = 0; i < 12; i++) push(10'h155, 10'h155, 10'h354);
        run_words("align");

        // Loopback: blanking with token 11, then data words
        do_reset("rst_lb");
        for (int i = 0; i < 12; i++) push(10'h354, 10'h354, 10'h2AB);
        push(10'h2AA, 10'h0F3, 10'h1C7);
        for (int i = 0; i < 5; i++) push(rand_data(), rand_data(), rand_data());
        run_words("loop");

        // Verify sequence broken by a non-token word
        do_reset("rst_bv");
        for (int i = 0; i < 5; i++) push(10'($urandom), 10'($urandom), 10'h354);
        for (int i = 0; i < 4; i++) push(10'($urandom), 10'($urandom), 10'h000);
        run_words("brk");

        // Loss of lock: 15 misses survive, the 16th drops lock
        do_reset("rst_loss");
        for (int i = 0; i < TR; i++) push(10'h155, 10'h155, 10'h354);
        for (int i = 0; i < LW - 1; i++) push(rand_data(), rand_data(), rand_data());
        push(10'h155, 10'h155, 10'h354);
        for (int i = 0; i < LW; i++) push(rand_data(), rand_data(), rand_data());
        run_words("loss");

        // Asynchronous reset between boundaries while locked, then relock
        do_reset("rst_ml");
        for (int i = 0; i < 10; i++) push(10'h155, 10'h0F3, 10'h354);
        run_words("prelock");
        for (int i = 0; i < 4; i++) begin
            TMDS_in = 3'($urandom);
            @(posedge clk_fast); #1;
        end
        chk1("midlock_locked", locked, 1'b1);
        chk10("midlock_blue", TMDS_blue, 10'h354);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_rst");
        do_reset("rst_hold");
        for (int i = 0; i < TR + 1; i++) push(10'h155, 10'h155, 10'h354);
        run_words("relock");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
